// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU task dispatcher and the cores it feeds.
package gpu_pkg;

    localparam int INS_PER_TASK = 16;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU    = 4'h1;
    localparam logic [3:0] OP_LOAD   = 4'h2;
    localparam logic [3:0] OP_STORE  = 4'h3;
    localparam logic [3:0] OP_BRANCH = 4'h4;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SEND, S_DRAIN} disp_state_t;

    typedef enum logic {FREE = 1'b0, BUSY = 1'b1} entry_t;

endpackage

// File: rtl/gpu_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module gpu_rr_arbiter
    import gpu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[(int'(rr_ptr) + i) % N]) begin
                valid = 1'b1;
                grant[(int'(rr_ptr) + i) % N] = 1'b1;
                idx = IW'((int'(rr_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/gpu_task_dispatcher.sv
// Streams stored 16-word programs to free cores over a shared bus and tracks their completion.
module gpu_task_dispatcher
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = 16,
    parameter int NUM_TASKS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           prog_we,
    input  logic [$clog2(NUM_TASKS)+3:0]   prog_addr,
    input  logic [15:0]                    prog_wdata,
    input  logic                           start,
    input  logic [$clog2(NUM_TASKS+1)-1:0] task_count,
    input  logic [NUM_CORES-1:0]           rtr,
    input  logic [NUM_CORES-1:0]           ready,
    output logic [15:0]                    instruction,
    output logic [NUM_CORES-1:0]           val_ins,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_TASKS+1)-1:0] tasks_done,
    output logic                           err
);

    localparam int SW = $clog2(NUM_TASKS);
    localparam int AW = SW + 4;
    localparam int CW = $clog2(NUM_TASKS + 1);
    localparam int KW = $clog2(NUM_CORES);

    disp_state_t state, next_state;

    logic [15:0]          mem [NUM_TASKS*INS_PER_TASK];
    entry_t               core_tbl [NUM_CORES];
    logic [CW-1:0]        count_q, task_idx, eff_count;
    logic [3:0]           word, rd_word;
    logic [KW-1:0]        sel, rr_ptr, arb_idx;
    logic [NUM_CORES-1:0] free_mask, finish, req, arb_grant;
    logic [KW:0]          fin_cnt;
    logic [AW-1:0]        rd_addr;
    logic                 arb_valid, any_busy, accept_start, pick, last_beat, more_tasks, proto_err;
    logic [15:0]          instruction_nxt;
    logic [NUM_CORES-1:0] val_ins_nxt;
    logic                 busy_nxt, done_nxt;

    // A core returning FREE is only visible through the registered table, so it cannot be re-picked that cycle.
    always_comb begin
        free_mask = '0;
        finish    = '0;
        fin_cnt   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            free_mask[k] = (core_tbl[k] == FREE);
            finish[k]    = (core_tbl[k] == BUSY) && ready[k];
            fin_cnt      = fin_cnt + {{KW{1'b0}}, finish[k]};
        end
    end

    assign any_busy     = (free_mask != '1);
    assign req          = free_mask & rtr;
    assign eff_count    = (task_count > CW'(NUM_TASKS)) ? CW'(NUM_TASKS) : task_count;
    assign accept_start = (state == S_IDLE) && start;
    assign pick         = (state == S_SELECT) && arb_valid;
    assign last_beat    = (state == S_SEND) && (word == 4'(INS_PER_TASK - 1));
    assign more_tasks   = (task_idx + CW'(1)) < count_q;
    assign rd_word      = (state == S_SEND) ? word + 4'd1 : 4'd0;
    assign rd_addr      = {task_idx[SW-1:0], rd_word};
    assign proto_err    = ((state == S_SEND) && !rtr[sel]) || (|(ready & ~rtr & free_mask));

    gpu_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = (eff_count == '0) ? S_IDLE : S_SELECT;
            S_SELECT: if (arb_valid) next_state = S_SEND;
            S_SEND:   if (last_beat) next_state = more_tasks ? S_SELECT : S_DRAIN;
            S_DRAIN:  if (!any_busy) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // The word shown next cycle is fetched one beat ahead so the bus stays registered without gaps.
    always_comb begin
        val_ins_nxt     = '0;
        instruction_nxt = '0;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    busy_nxt = (eff_count != '0);
                    done_nxt = (eff_count == '0);
                end
            end
            S_SELECT: begin
                if (arb_valid) begin
                    val_ins_nxt     = arb_grant;
                    instruction_nxt = mem[rd_addr];
                end
            end
            S_SEND: begin
                if (!last_beat) begin
                    val_ins_nxt     = val_ins;
                    instruction_nxt = mem[rd_addr];
                end
            end
            S_DRAIN: begin
                if (!any_busy) begin
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && prog_we) mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_ins     <= '0;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tasks_done  <= '0;
            err         <= 1'b0;
            count_q     <= '0;
            task_idx    <= '0;
            word        <= '0;
            sel         <= '0;
            rr_ptr      <= '0;
            for (int k = 0; k < NUM_CORES; k++) core_tbl[k] <= FREE;
        end else begin
            val_ins     <= val_ins_nxt;
            instruction <= instruction_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            if (accept_start) begin
                count_q    <= eff_count;
                task_idx   <= '0;
                tasks_done <= '0;
                err        <= 1'b0;
            end else begin
                tasks_done <= tasks_done + CW'(fin_cnt);
                err        <= err | proto_err;
            end
            for (int k = 0; k < NUM_CORES; k++) begin
                if (finish[k]) core_tbl[k] <= FREE;
            end
            if (pick) begin
                sel    <= arb_idx;
                word   <= '0;
                rr_ptr <= (arb_idx == KW'(NUM_CORES - 1)) ? '0 : arb_idx + KW'(1);
            end
            if (state == S_SEND) begin
                word <= word + 4'd1;
                if (last_beat) begin
                    core_tbl[sel] <= BUSY;
                    task_idx      <= task_idx + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_task_dispatcher.sv
// Self-checking bench: scenario table, hand-written corner cases and randomized jobs against a core/bus model.
module tb_gpu_task_dispatcher;
    import gpu_pkg::*;

    localparam int NC = 16;
    localparam int NT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [6:0]  prog_addr;
    logic [15:0] prog_wdata;
    logic        start;
    logic [3:0]  task_count;
    logic [15:0] rtr, ready;
    logic [15:0] instruction;
    logic [15:0] val_ins;
    logic        busy, done, err;
    logic [3:0]  tasks_done;

    always #5 clk = ~clk;

    gpu_task_dispatcher #(.NUM_CORES(NC), .NUM_TASKS(NT)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .start       (start),
        .task_count  (task_count),
        .rtr         (rtr),
        .ready       (ready),
        .instruction (instruction),
        .val_ins     (val_ins),
        .busy        (busy),
        .done        (done),
        .tasks_done  (tasks_done),
        .err         (err)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_mem [NT*16];
    logic [15:0] core_en, rtr_model, force_low;
    int          rx_cnt [NC];
    int          run_cnt [NC];
    int          lat [NC];
    bit          running [NC];
    int          mon_beat, mon_loads, done_pulses;
    logic [15:0] mon_core;
    int          load_core [$];

    assign rtr = rtr_model & ~force_low;

    typedef struct {
        logic [3:0]  count;
        logic [15:0] mask;
        int          latency;
        int          exp_loads;
        int          exp_c0, exp_c1, exp_c2;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus observer: each load must be 16 back-to-back one-hot beats carrying the next slot in order.
    task automatic monitor();
        if (val_ins !== 16'h0) begin
            if (mon_beat == 16) begin
                check_output("load_too_long", 32'(val_ins), 32'h0);
            end else begin
                if (mon_beat == 0) begin
                    check_output("val_ins_onehot", 32'($onehot(val_ins)), 32'h1);
                    mon_core = val_ins;
                    load_core.push_back($clog2(val_ins));
                end else begin
                    check_output("val_ins_steady", 32'(val_ins), 32'(mon_core));
                end
                check_output("instruction", 32'(instruction), 32'(exp_mem[(mon_loads % NT)*16 + mon_beat]));
                mon_beat++;
            end
        end else if (mon_beat == 16) begin
            mon_loads++;
            mon_beat = 0;
        end else if (mon_beat != 0) begin
            check_output("load_truncated", 32'(mon_beat), 32'd16);
            mon_beat = 0;
        end
        if (done === 1'b1) done_pulses++;
    endtask

    // Core behaviour: receive 16 words, run for lat cycles with rtr low, then raise ready until reloaded.
    task automatic cores();
        for (int k = 0; k < NC; k++) begin
            if (val_ins[k] === 1'b1) begin
                ready[k] = 1'b0;
                rx_cnt[k]++;
                if (rx_cnt[k] == 16) begin
                    rx_cnt[k]  = 0;
                    running[k] = 1'b1;
                    run_cnt[k] = lat[k];
                end
            end else if (running[k]) begin
                if (run_cnt[k] <= 1) begin
                    running[k]   = 1'b0;
                    ready[k]     = 1'b1;
                    rtr_model[k] = core_en[k];
                end else begin
                    run_cnt[k]--;
                    rtr_model[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        cores();
    endtask

    task automatic init_cores(input logic [15:0] mask, input int latency);
        core_en   = mask;
        rtr_model = mask;
        force_low = '0;
        ready     = '0;
        for (int k = 0; k < NC; k++) begin
            running[k] = 1'b0;
            rx_cnt[k]  = 0;
            run_cnt[k] = 0;
            lat[k]     = latency;
        end
    endtask

    task automatic clear_monitor();
        mon_beat    = 0;
        mon_loads   = 0;
        done_pulses = 0;
        load_core.delete();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        start   = 1'b0;
        prog_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_monitor();
    endtask

    task automatic write_word(input logic [6:0] addr, input logic [15:0] data);
        prog_we    = 1'b1;
        prog_addr  = addr;
        prog_wdata = data;
        step();
        prog_we      = 1'b0;
        exp_mem[addr] = data;
    endtask

    task automatic apply_stimulus(input logic [3:0] count);
        clear_monitor();
        start      = 1'b1;
        task_count = count;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget && done_pulses == 0; i++) step();
        check_output("done_timeout", 32'(done_pulses > 0), 32'h1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ec [3];
        int bits [$];
        int exp_loads;
        int i;
        logic [15:0] mask;
        logic [3:0]  cnt;

        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; task_count = '0;
        init_cores('0, 1);
        clear_monitor();

        vecs[0] = '{4'd1,  16'h0001, 3,  1, 0,  -1, -1};
        vecs[1] = '{4'd3,  16'h0003, 20, 3, 0,  1,  0};
        vecs[2] = '{4'd0,  16'h0001, 3,  0, -1, -1, -1};
        vecs[3] = '{4'd2,  16'h8000, 5,  2, 15, 15, -1};
        vecs[4] = '{4'd15, 16'h00F0, 10, 8, 4,  5,  6};
        vecs[5] = '{4'd3,  16'h0006, 2,  3, 1,  2,  1};

        do_reset();
        check_output("rst_val_ins", 32'(val_ins), 32'h0);
        check_output("rst_instruction", 32'(instruction), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_done", 32'(done), 32'h0);
        check_output("rst_tasks_done", 32'(tasks_done), 32'h0);
        check_output("rst_err", 32'(err), 32'h0);

        for (int s = 0; s < NT; s++)
            for (int w = 0; w < 16; w++)
                write_word(7'(s*16 + w), (s == 0) ? 16'(16'h1000 + w) : 16'($urandom));

        $display("[TB] scenario table");
        for (int v = 0; v < 6; v++) begin
            init_cores(vecs[v].mask, vecs[v].latency);
            do_reset();
            apply_stimulus(vecs[v].count);
            check_output("busy_after_start", 32'(busy), 32'(vecs[v].count != 0));
            check_output("done_after_start", 32'(done), 32'(vecs[v].count == 0));
            wait_done(3000);
            repeat (3) step();
            check_output("done_single_pulse", 32'(done_pulses), 32'd1);
            check_output("loads", 32'(mon_loads), 32'(vecs[v].exp_loads));
            check_output("tasks_done", 32'(tasks_done), 32'(vecs[v].exp_loads));
            check_output("err_clean", 32'(err), 32'h0);
            check_output("busy_end", 32'(busy), 32'h0);
            ec = '{vecs[v].exp_c0, vecs[v].exp_c1, vecs[v].exp_c2};
            for (int j = 0; j < 3; j++)
                if (ec[j] >= 0)
                    check_output("core_order", (j < load_core.size()) ? 32'(load_core[j]) : 32'hFFFF_FFFF, 32'(ec[j]));
        end

        $display("[TB] reset during load");
        init_cores(16'h0001, 3);
        do_reset();
        apply_stimulus(4'd1);
        for (i = 0; i < 100 && mon_beat != 8; i++) step();
        check_output("reached_word7", 32'(mon_beat), 32'd8);
        reset = 1'b1;
        #1;
        check_output("async_val_ins_drop", 32'(val_ins), 32'h0);
        check_output("async_busy_drop", 32'(busy), 32'h0);
        clear_monitor();
        step();
        step();
        reset = 1'b0;
        init_cores(16'h0001, 3);
        apply_stimulus(4'd1);
        wait_done(500);
        check_output("restart_loads", 32'(mon_loads), 32'd1);
        check_output("restart_tasks_done", 32'(tasks_done), 32'd1);

        $display("[TB] completion during another load");
        init_cores(16'h000C, 30);
        lat[2] = 4;
        do_reset();
        apply_stimulus(4'd2);
        for (i = 0; i < 200 && !(load_core.size() == 2 && mon_beat >= 10); i++) step();
        check_output("mid_send_val_ins", 32'(val_ins), 32'h0008);
        check_output("mid_send_tasks_done", 32'(tasks_done), 32'd1);
        start = 1'b1;
        task_count = 4'd5;
        step();
        start = 1'b0;
        wait_done(500);
        check_output("ignored_start_loads", 32'(mon_loads), 32'd2);
        check_output("ignored_start_tasks_done", 32'(tasks_done), 32'd2);
        check_output("first_core", (load_core.size() > 0) ? 32'(load_core[0]) : 32'hFFFF_FFFF, 32'd2);
        check_output("second_core", (load_core.size() > 1) ? 32'(load_core[1]) : 32'hFFFF_FFFF, 32'd3);

        $display("[TB] protocol errors");
        init_cores(16'h0001, 5);
        do_reset();
        apply_stimulus(4'd1);
        for (i = 0; i < 100 && mon_beat != 5; i++) step();
        force_low = 16'h0001;
        step();
        force_low = '0;
        step();
        check_output("err_rtr_drop", 32'(err), 32'h1);
        wait_done(500);
        check_output("err_sticky", 32'(err), 32'h1);
        check_output("err_full_load", 32'(mon_loads), 32'd1);
        apply_stimulus(4'd0);
        check_output("err_cleared_by_start", 32'(err), 32'h0);
        init_cores('0, 1);
        ready[5] = 1'b1;
        step();
        ready[5] = 1'b0;
        step();
        check_output("err_ready_without_rtr", 32'(err), 32'h1);

        $display("[TB] randomized jobs");
        for (int r = 0; r < 6; r++) begin
            mask = 16'($urandom_range(1, 65535));
            cnt  = 4'($urandom_range(1, 15));
            init_cores(mask, 1);
            for (int k = 0; k < NC; k++) lat[k] = $urandom_range(1, 40);
            do_reset();
            begin
                int slot;
                slot = $urandom_range(0, NT-1);
                for (int w = 0; w < 16; w++) write_word(7'(slot*16 + w), 16'($urandom));
            end
            exp_loads = (cnt > NT) ? NT : int'(cnt);
            apply_stimulus(cnt);
            for (i = 0; i < 3000 && done_pulses == 0; i++) begin
                prog_we    = (i == 10);
                prog_addr  = 7'($urandom);
                prog_wdata = 16'($urandom);
                step();
            end
            prog_we = 1'b0;
            check_output("rnd_done_timeout", 32'(done_pulses > 0), 32'h1);
            repeat (2) step();
            check_output("rnd_done_pulses", 32'(done_pulses), 32'd1);
            check_output("rnd_loads", 32'(mon_loads), 32'(exp_loads));
            check_output("rnd_tasks_done", 32'(tasks_done), 32'(exp_loads));
            check_output("rnd_err", 32'(err), 32'h0);
            bits.delete();
            for (int k = 0; k < NC; k++) if (mask[k]) bits.push_back(k);
            for (int j = 0; j < load_core.size(); j++) begin
                check_output("rnd_core_enabled", 32'(mask[load_core[j]]), 32'h1);
                if (j < bits.size())
                    check_output("rnd_rr_first_pass", 32'(load_core[j]), 32'(bits[j]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
